// File: rtl/conv1_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv1_seq_pkg
// Description : Shared definitions for the conv layer 1 sequencer.
//               Provides the default geometry, derived element counts,
//               counter widths and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package conv1_seq_pkg;

    // Default geometry of conv layer 1
    localparam int c_I_SIZE  = 28;
    localparam int c_K_SIZE  = 5;
    localparam int c_CO      = 4;
    localparam int c_I_BW    = 8;
    localparam int c_W_BW    = 8;
    localparam int c_O_SIZE  = 12;
    localparam int c_TIMEOUT = 4096;

    // Element counts for one frame
    localparam int c_N_W    = c_CO * c_K_SIZE * c_K_SIZE;
    localparam int c_N_PX   = c_I_SIZE * c_I_SIZE;
    localparam int c_N_POOL = c_CO * c_O_SIZE * c_O_SIZE;

    // Counter widths. Result counters get one spare code so that a
    // saturated count can never alias the expected final value.
    localparam int c_W_IDX_W = $clog2(c_N_W);
    localparam int c_PX_CW   = $clog2(c_N_PX + 1);
    localparam int c_CH_CW   = $clog2(c_CO + 2);
    localparam int c_POOL_CW = $clog2(c_N_POOL + 2);
    localparam int c_WD_CW   = $clog2(c_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_W   = 3'd1,
        ST_LOAD_IMG = 3'd2,
        ST_RUN      = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv1_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : conv1_layer_sequencer_if
// Description : Bundles the source handshakes, layer control and status
//               signals of the conv layer 1 sequencer.
//               slave  : the sequencer side (consumes i_*, drives o_*)
//               master : the environment side (drives i_*, consumes o_*)
//               Signals: i_start/i_keep_w frame control; i_w_valid/i_w_data/
//               o_w_ready weight stream; i_px_valid/i_px_data/o_px_ready
//               pixel stream; o_layer_* and i_layer_* layer control/status;
//               o_busy/o_done/o_err sequencer status.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv1_layer_sequencer_if #(
    parameter int I_BW = 8,
    parameter int W_BW = 8,
    parameter int N_W  = 100
);
    logic                  i_start;
    logic                  i_keep_w;
    logic                  i_w_valid;
    logic [W_BW-1:0]       i_w_data;
    logic                  o_w_ready;
    logic                  i_px_valid;
    logic [I_BW-1:0]       i_px_data;
    logic                  o_px_ready;
    logic                  o_layer_ce;
    logic [I_BW-1:0]       o_layer_fmap;
    logic [N_W*W_BW-1:0]   o_layer_weight;
    logic                  o_rst_processEnd;
    logic                  i_layer_en;
    logic                  i_layer_ch_end;
    logic                  i_layer_allch_end;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport slave (
        input  i_start, i_keep_w, i_w_valid, i_w_data, i_px_valid, i_px_data,
               i_layer_en, i_layer_ch_end, i_layer_allch_end,
        output o_w_ready, o_px_ready, o_layer_ce, o_layer_fmap, o_layer_weight,
               o_rst_processEnd, o_busy, o_done, o_err
    );

    modport master (
        output i_start, i_keep_w, i_w_valid, i_w_data, i_px_valid, i_px_data,
               i_layer_en, i_layer_ch_end, i_layer_allch_end,
        input  o_w_ready, o_px_ready, o_layer_ce, o_layer_fmap, o_layer_weight,
               o_rst_processEnd, o_busy, o_done, o_err
    );

endinterface
`default_nettype wire

// File: rtl/conv1_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : conv1_weight_loader
// Description : Serial-to-parallel weight register. Each write stores the
//               byte at the slot given by the running acceptance index.
//               Ports: clk, rst; i_clear restarts the index; i_wr/i_data
//               write one byte; o_weight is the parallel weight vector;
//               o_last flags that the next write fills the final slot;
//               o_wvalid is set once a full set has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module conv1_weight_loader #(
    parameter int N_W  = 100,
    parameter int W_BW = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_clear,
    input  wire logic                i_wr,
    input  wire logic [W_BW-1:0]     i_data,
    output logic      [N_W*W_BW-1:0] o_weight,
    output logic                     o_last,
    output logic                     o_wvalid
);

    localparam int c_IDX_W = (N_W > 1) ? $clog2(N_W) : 1;

    logic [c_IDX_W-1:0]   r_idx_q,    w_idx_d;
    logic [N_W*W_BW-1:0]  r_weight_q, w_weight_d;
    logic                 r_wvalid_q, w_wvalid_d;

    assign o_last   = (r_idx_q == c_IDX_W'(N_W - 1));
    assign o_weight = r_weight_q;
    assign o_wvalid = r_wvalid_q;

    always_comb begin
        w_idx_d    = r_idx_q;
        w_weight_d = r_weight_q;
        w_wvalid_d = r_wvalid_q;
        if (i_clear) begin
            w_idx_d = '0;
        end else if (i_wr) begin
            w_weight_d[int'(r_idx_q) * W_BW +: W_BW] = i_data;
            // The index parks on the final slot; the FSM leaves the load
            // state on this same edge, so no further writes arrive.
            if (o_last) begin
                w_wvalid_d = 1'b1;
            end else begin
                w_idx_d = r_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx_q    <= '0;
            r_weight_q <= '0;
            r_wvalid_q <= 1'b0;
        end else begin
            r_idx_q    <= w_idx_d;
            r_weight_q <= w_weight_d;
            r_wvalid_q <= w_wvalid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv1_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv1_layer_sequencer
// Description : Drives one conv layer 1 instance through a full frame:
//               weight load, pixel streaming into the layer input memory,
//               a run phase guarded by a watchdog, and a one-cycle
//               processEnd pulse that closes the frame.
//               Ports: clk, rst (synchronous, active high); bus - slave
//               modport carrying source handshakes, layer control/status
//               and sequencer status (o_busy, o_done, sticky o_err).
// Revision    : 1.0 - initial release
// ============================================================================
module conv1_layer_sequencer
    import conv1_seq_pkg::*;
#(
    parameter int I_SIZE  = c_I_SIZE,
    parameter int K_SIZE  = c_K_SIZE,
    parameter int CO      = c_CO,
    parameter int I_BW    = c_I_BW,
    parameter int W_BW    = c_W_BW,
    parameter int O_SIZE  = c_O_SIZE,
    parameter int TIMEOUT = c_TIMEOUT
) (
    input  wire logic                clk,
    input  wire logic                rst,
    conv1_layer_sequencer_if.slave   bus
);

    localparam int c_NW    = CO * K_SIZE * K_SIZE;
    localparam int c_NPX   = I_SIZE * I_SIZE;
    localparam int c_NPOOL = CO * O_SIZE * O_SIZE;
    localparam int c_PXW   = $clog2(c_NPX + 1);
    localparam int c_CHW   = $clog2(CO + 2);
    localparam int c_POOLW = $clog2(c_NPOOL + 2);
    localparam int c_WDW   = $clog2(TIMEOUT + 1);

    state_t             r_state_q,    w_state_d;
    logic [c_PXW-1:0]   r_px_cnt_q,   w_px_cnt_d;
    logic [c_CHW-1:0]   r_ch_cnt_q,   w_ch_cnt_d;
    logic [c_POOLW-1:0] r_pool_cnt_q, w_pool_cnt_d;
    logic [c_WDW-1:0]   r_wd_q,       w_wd_d;
    logic               r_err_q,      w_err_d;
    logic               r_ce_q,       w_ce_d;
    logic [I_BW-1:0]    r_fmap_q,     w_fmap_d;

    logic                 w_start_acc;
    logic                 w_w_acc;
    logic                 w_px_acc;
    logic                 w_px_last;
    logic                 w_wl_last;
    logic                 w_wvalid;
    logic [c_NW*W_BW-1:0] w_weight;

    assign w_start_acc = bus.i_start    && (r_state_q == ST_IDLE);
    assign w_w_acc     = bus.i_w_valid  && (r_state_q == ST_LOAD_W);
    assign w_px_acc    = bus.i_px_valid && (r_state_q == ST_LOAD_IMG);
    assign w_px_last   = (r_px_cnt_q == c_PXW'(c_NPX - 1));

    conv1_weight_loader #(
        .N_W  (c_NW),
        .W_BW (W_BW)
    ) u_weight_loader (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_start_acc),
        .i_wr     (w_w_acc),
        .i_data   (bus.i_w_data),
        .o_weight (w_weight),
        .o_last   (w_wl_last),
        .o_wvalid (w_wvalid)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_px_cnt_d   = r_px_cnt_q;
        w_ch_cnt_d   = r_ch_cnt_q;
        w_pool_cnt_d = r_pool_cnt_q;
        w_wd_d       = r_wd_q;
        w_err_d      = r_err_q;
        w_fmap_d     = r_fmap_q;
        w_ce_d       = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_px_cnt_d   = '0;
                    w_ch_cnt_d   = '0;
                    w_pool_cnt_d = '0;
                    w_wd_d       = '0;
                    w_err_d      = 1'b0;
                    w_state_d    = (!bus.i_keep_w || !w_wvalid) ? ST_LOAD_W : ST_LOAD_IMG;
                end
            end

            ST_LOAD_W: begin
                if (w_w_acc && w_wl_last) begin
                    w_state_d = ST_LOAD_IMG;
                end
            end

            ST_LOAD_IMG: begin
                // ce follows each accepted pixel by one cycle; idle cycles
                // leave ce low so the layer holds its write address.
                if (w_px_acc) begin
                    w_fmap_d = bus.i_px_data;
                    w_ce_d   = 1'b1;
                    if (r_px_cnt_q != '1) begin
                        w_px_cnt_d = r_px_cnt_q + 1'b1;
                    end
                    if (w_px_last) begin
                        w_state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                w_ce_d = 1'b1;
                if (bus.i_layer_en && (r_pool_cnt_q != '1)) begin
                    w_pool_cnt_d = r_pool_cnt_q + 1'b1;
                end
                if (bus.i_layer_ch_end && (r_ch_cnt_q != '1)) begin
                    w_ch_cnt_d = r_ch_cnt_q + 1'b1;
                end
                if (bus.i_layer_allch_end) begin
                    w_state_d = ST_FINISH;
                    w_ce_d    = 1'b0;
                end else if (bus.i_layer_en || bus.i_layer_ch_end) begin
                    w_wd_d = '0;
                end else if (r_wd_q == c_WDW'(TIMEOUT - 1)) begin
                    // This idle cycle is the TIMEOUT-th in a row.
                    w_wd_d    = r_wd_q + 1'b1;
                    w_err_d   = 1'b1;
                    w_state_d = ST_FINISH;
                    w_ce_d    = 1'b0;
                end else begin
                    w_wd_d = r_wd_q + 1'b1;
                end
            end

            ST_FINISH: begin
                if ((r_ch_cnt_q != c_CHW'(CO)) || (r_pool_cnt_q != c_POOLW'(c_NPOOL))) begin
                    w_err_d = 1'b1;
                end
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_px_cnt_q   <= '0;
            r_ch_cnt_q   <= '0;
            r_pool_cnt_q <= '0;
            r_wd_q       <= '0;
            r_err_q      <= 1'b0;
            r_ce_q       <= 1'b0;
            r_fmap_q     <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_px_cnt_q   <= w_px_cnt_d;
            r_ch_cnt_q   <= w_ch_cnt_d;
            r_pool_cnt_q <= w_pool_cnt_d;
            r_wd_q       <= w_wd_d;
            r_err_q      <= w_err_d;
            r_ce_q       <= w_ce_d;
            r_fmap_q     <= w_fmap_d;
        end
    end

    assign bus.o_w_ready        = (r_state_q == ST_LOAD_W);
    assign bus.o_px_ready       = (r_state_q == ST_LOAD_IMG);
    assign bus.o_layer_ce       = r_ce_q;
    assign bus.o_layer_fmap     = r_fmap_q;
    assign bus.o_layer_weight   = w_weight;
    assign bus.o_rst_processEnd = (r_state_q == ST_FINISH);
    assign bus.o_done           = (r_state_q == ST_FINISH);
    assign bus.o_busy           = (r_state_q != ST_IDLE);
    assign bus.o_err            = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv1_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv1_layer_sequencer
// Description : Self-checking bench for conv1_layer_sequencer. Drives
//               randomized weight/pixel streams and a simple layer model,
//               and compares against expectations derived from the frame
//               rules (element counts, handshake acceptance, error rules).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv1_layer_sequencer;
    import conv1_seq_pkg::*;

    localparam int c_WT_W = c_N_W * c_W_BW;

    logic clk = 1'b0;
    logic rst;

    int n_vec  = 0;
    int n_fail = 0;

    bit               wv_model = 1'b0;
    logic [c_WT_W-1:0] exp_wt  = '0;

    conv1_layer_sequencer_if #(.I_BW(c_I_BW), .W_BW(c_W_BW), .N_W(c_N_W)) bus ();

    conv1_layer_sequencer #(
        .I_SIZE (c_I_SIZE),
        .K_SIZE (c_K_SIZE),
        .CO     (c_CO),
        .I_BW   (c_I_BW),
        .W_BW   (c_W_BW),
        .O_SIZE (c_O_SIZE),
        .TIMEOUT(c_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [c_WT_W-1:0] obs, input logic [c_WT_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete frame. px_mode: 0 = pixel every cycle, 1 = every 3rd
    // cycle, 2 = random. silent: layer never answers in RUN.
    task automatic run_frame(input bit keep, input int px_mode, input int n_en,
                             input bit silent, input bit wt_incr);
        bit                exp_lw, exp_err, v, acc;
        int                acc_n, guard, cyc, ce_cnt, ce_bad, wr_bad, run_cyc, ch_sent, gap;
        logic [c_W_BW-1:0] b;
        logic [c_I_BW-1:0] pd;

        exp_lw = !keep || !wv_model;
        bus.i_start  = 1'b1;
        bus.i_keep_w = keep;
        tick();
        bus.i_start  = 1'b0;
        bus.i_keep_w = 1'b0;
        chk("start_busy", bus.o_busy, 1);
        chk("start_err_clr", bus.o_err, 0);
        chk("start_path_lw", bus.o_w_ready, exp_lw);

        if (exp_lw) begin
            acc_n = 0;
            guard = 0;
            while (acc_n < c_N_W && guard < 2000) begin
                b   = wt_incr ? acc_n[c_W_BW-1:0] : c_W_BW'($urandom);
                v   = ($urandom_range(0, 3) != 0);
                bus.i_w_valid = v;
                bus.i_w_data  = b;
                acc = v && (bus.o_w_ready === 1'b1);
                if (acc) exp_wt[acc_n*c_W_BW +: c_W_BW] = b;
                tick();
                guard++;
                if (acc) acc_n++;
            end
            bus.i_w_valid = 1'b0;
            wv_model = 1'b1;
            chk("wload_count", acc_n, c_N_W);
            chk("wload_exit", {bus.o_w_ready, bus.o_px_ready}, 2'b01);
        end
        chk("weights", bus.o_layer_weight, exp_wt);

        acc_n  = 0;
        cyc    = 0;
        ce_cnt = 0;
        ce_bad = 0;
        wr_bad = 0;
        while (acc_n < c_N_PX && cyc < 12000) begin
            case (px_mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 3) == 2);
                default: v = 1'($urandom_range(0, 1));
            endcase
            pd = c_I_BW'($urandom);
            bus.i_px_valid = v;
            bus.i_px_data  = pd;
            acc = v && (bus.o_px_ready === 1'b1);
            if (bus.o_w_ready !== 1'b0) wr_bad++;
            tick();
            cyc++;
            if (bus.o_layer_ce !== acc) ce_bad++;
            if (acc && (bus.o_layer_fmap !== pd)) ce_bad++;
            if (bus.o_layer_ce === 1'b1) ce_cnt++;
            if (acc) acc_n++;
        end
        bus.i_px_valid = 1'b0;
        chk("px_accepts", acc_n, c_N_PX);
        chk("ce_pattern", ce_bad, 0);
        chk("ce_count", ce_cnt, c_N_PX);
        chk("run_entry", {bus.o_busy, bus.o_px_ready, bus.o_layer_ce}, 3'b101);

        ce_bad  = 0;
        run_cyc = 0;
        ch_sent = 0;
        if (silent) begin
            while (bus.o_rst_processEnd !== 1'b1 && run_cyc < c_TIMEOUT + 50) begin
                if (bus.o_layer_ce !== 1'b1) ce_bad++;
                if (bus.o_w_ready !== 1'b0) wr_bad++;
                tick();
                run_cyc++;
            end
            chk("wd_cycles", run_cyc, c_TIMEOUT);
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < n_en; i++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    if (bus.o_layer_ce !== 1'b1) ce_bad++;
                    tick();
                end
                bus.i_layer_en        = 1'b1;
                bus.i_layer_ch_end    = (((i + 1) % (n_en / c_CO)) == 0) && (ch_sent < c_CO);
                bus.i_layer_allch_end = (i == n_en - 1);
                if (bus.i_layer_ch_end) ch_sent++;
                if (bus.o_layer_ce !== 1'b1) ce_bad++;
                tick();
                bus.i_layer_en        = 1'b0;
                bus.i_layer_ch_end    = 1'b0;
                bus.i_layer_allch_end = 1'b0;
            end
            exp_err = (n_en != c_N_POOL) || (ch_sent != c_CO);
        end
        chk("run_ce_high", ce_bad, 0);
        chk("no_wready_after_load", wr_bad, 0);
        chk("finish_pulse", {bus.o_rst_processEnd, bus.o_done, bus.o_layer_ce, bus.o_busy}, 4'b1101);
        tick();
        chk("finish_exit", {bus.o_rst_processEnd, bus.o_done, bus.o_busy}, 3'b000);
        chk("frame_err", bus.o_err, exp_err);
        chk("weights_hold", bus.o_layer_weight, exp_wt);
    endtask

    initial begin
        rst                   = 1'b1;
        bus.i_start           = 1'b0;
        bus.i_keep_w          = 1'b0;
        bus.i_w_valid         = 1'b0;
        bus.i_w_data          = '0;
        bus.i_px_valid        = 1'b0;
        bus.i_px_data         = '0;
        bus.i_layer_en        = 1'b0;
        bus.i_layer_ch_end    = 1'b0;
        bus.i_layer_allch_end = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_ctrl", {bus.o_busy, bus.o_w_ready, bus.o_px_ready, bus.o_layer_ce,
                           bus.o_rst_processEnd, bus.o_done, bus.o_err}, 0);
        chk("reset_fmap", bus.o_layer_fmap, 0);
        chk("reset_weight", bus.o_layer_weight, 0);

        // Full frame, incrementing weights, pixel every cycle
        run_frame(1'b0, 0, c_N_POOL, 1'b0, 1'b1);
        chk("w_field7", bus.o_layer_weight[7*c_W_BW +: c_W_BW], 7);
        // Reuse weights, gappy pixels
        run_frame(1'b1, 1, c_N_POOL, 1'b0, 1'b0);
        // Short pooled count -> error
        run_frame(1'b1, 2, c_N_POOL - 1, 1'b0, 1'b0);
        // Fresh random weights, error cleared by start
        run_frame(1'b0, 2, c_N_POOL, 1'b0, 1'b0);
        // Layer stays silent -> watchdog
        run_frame(1'b1, 0, 0, 1'b1, 1'b0);

        // Reset in the middle of the image load
        bus.i_start  = 1'b1;
        bus.i_keep_w = 1'b1;
        tick();
        bus.i_start  = 1'b0;
        chk("t6_keep_path", {bus.o_w_ready, bus.o_px_ready}, 2'b01);
        for (int i = 0; i < 300; i++) begin
            bus.i_px_valid = 1'b1;
            bus.i_px_data  = c_I_BW'($urandom);
            tick();
        end
        bus.i_px_valid = 1'b0;
        bus.i_start    = 1'b1;
        bus.i_keep_w   = 1'b0;
        tick();
        bus.i_start    = 1'b0;
        chk("start_ignored", {bus.o_w_ready, bus.o_px_ready, bus.o_busy}, 3'b011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wv_model = 1'b0;
        exp_wt   = '0;
        chk("rst_ctrl", {bus.o_busy, bus.o_w_ready, bus.o_px_ready, bus.o_layer_ce,
                         bus.o_rst_processEnd, bus.o_done, bus.o_err}, 0);
        chk("rst_fmap", bus.o_layer_fmap, 0);
        chk("rst_weight", bus.o_layer_weight, 0);
        // keep_w=1 must still reload because reset invalidated the weights
        run_frame(1'b1, 2, c_N_POOL, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
